shift_step_sequencer: RTL and testbench

- Multi-cycle logical shifter for an N-bit operand by a run-time amount (0..N-1), left or right.
- Reuses one fixed-distance shift stage (STEP bits) plus a 1-bit stage, one step per clock, instead of a full barrel shifter.
- Sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.
- Processes one operation at a time.

---
 rtl/shift_step_pkg.sv | 24 ++
 rtl/shift_stage.sv | 31 +++
 rtl/shift_step_sequencer.sv | 175 +++++++++++++++++
 tb/tb_shift_step_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_step_pkg.sv
// -----------------------------------------------------------------------------
// shift_step_pkg
// Shared types and helpers for the multi-cycle step shifter.
//   state_t      : sequencer states (IDLE, SHIFT, DONE)
//   DIR_LEFT/RIGHT: encoding of the shift direction input
//   cnt_width()  : width of the shift-amount and step counters for an N-bit operand
// -----------------------------------------------------------------------------
package shift_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // A single-bit counter is still needed when N is 2.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Combinational fixed-distance logical shift by S bits.
//   a    : operand (N bits)
//   dir  : 0 = left (zero fill), 1 = right
//   fill : bit shifted in from the top on right shifts
//   res  : shifted operand (N bits)
// -----------------------------------------------------------------------------
module shift_stage
  import shift_step_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] a,
  input  logic         dir,
  input  logic         fill,
  output logic [N-1:0] res
);

  // Select the left or right shift by S positions.
  always_comb begin
    res = a;
    if (dir == DIR_RIGHT) begin
      res = {{S{fill}}, a[N-1:S]};
    end else begin
      res = {a[N-S-1:0], {S{1'b0}}};
    end
  end

endmodule

// File: rtl/shift_step_sequencer.sv
// -----------------------------------------------------------------------------
// shift_step_sequencer
// Multi-cycle logical shifter: an N-bit operand is shifted by a run-time amount
// (0..N-1) using one coarse STEP-bit stage and one 1-bit stage, one step per
// clock. The amount is split into q = amt / STEP coarse steps followed by
// r = amt % STEP fine steps.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   up_valid/up_ready   : request handshake (accepted only in IDLE)
//   up_data, up_amt     : operand and shift amount
//   up_dir              : 0 = left, 1 = right
//   up_arith            : sign-fill request for right shifts
//   down_valid/ready    : result handshake (result held until accepted)
//   down_data           : shifted result
//   busy                : an operation is in flight
//
// Build option:
//   SHIFT_STEP_SEQUENCER_ARITH_EN - when defined, right shifts requested with
//   up_arith=1 fill with the operand sign; otherwise every shift zero-fills.
// -----------------------------------------------------------------------------
module shift_step_sequencer
  import shift_step_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [N-1:0]         up_data,
  input  logic [$clog2(N)-1:0] up_amt,
  input  logic                 up_dir,
  input  logic                 up_arith,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [N-1:0]         down_data,
  output logic                 busy
);

  localparam int             CW     = cnt_width(N);
  localparam logic [CW-1:0]  STEP_W = CW'(STEP);
  localparam logic [CW-1:0]  ONE_W  = CW'(1);
  localparam logic [CW-1:0]  ZERO_W = CW'(0);

  state_t         state_r, state_s;
  logic [N-1:0]   data_r, data_s;
  logic           dir_r, dir_s;
  logic [CW-1:0]  q_r, q_s;
  logic [CW-1:0]  r_r, r_s;
  logic [CW-1:0]  amt_q_s, amt_r_s;
  logic           fill_s;
  logic [N-1:0]   coarse_res_s, fine_res_s;

  assign amt_q_s = CW'(CW'(up_amt) / STEP_W);
  assign amt_r_s = CW'(CW'(up_amt) % STEP_W);

`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
  logic arith_r, arith_s;

  // Current MSB equals the original sign after any number of sign-filling steps.
  assign fill_s = arith_r & (dir_r == DIR_RIGHT) & data_r[N-1];
`else
  logic unused_arith_s;

  assign unused_arith_s = up_arith;
  assign fill_s         = 1'b0;
`endif

  shift_stage #(.N(N), .S(STEP)) u_coarse (
    .a    (data_r),
    .dir  (dir_r),
    .fill (fill_s),
    .res  (coarse_res_s)
  );

  shift_stage #(.N(N), .S(1)) u_fine (
    .a    (data_r),
    .dir  (dir_r),
    .fill (fill_s),
    .res  (fine_res_s)
  );

  // Next-state, datapath and counter update for the sequencer.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    dir_s   = dir_r;
    q_s     = q_r;
    r_s     = r_r;
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
    arith_s = arith_r;
`endif
    case (state_r)
      IDLE: begin
        if (up_valid) begin
          data_s = up_data;
          dir_s  = up_dir;
          q_s    = amt_q_s;
          r_s    = amt_r_s;
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
          arith_s = up_arith;
`endif
          if ((amt_q_s != ZERO_W) || (amt_r_s != ZERO_W)) begin
            state_s = SHIFT;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // Coarse steps are used up first, then the 1-bit remainder.
        if (q_r != ZERO_W) begin
          data_s = coarse_res_s;
          q_s    = q_r - ONE_W;
          if ((q_r == ONE_W) && (r_r == ZERO_W)) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          data_s = fine_res_s;
          r_s    = r_r - ONE_W;
          if (r_r == ONE_W) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end
      end
      DONE: begin
        if (down_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      data_r  <= {N{1'b0}};
      dir_r   <= 1'b0;
      q_r     <= ZERO_W;
      r_r     <= ZERO_W;
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
      arith_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      dir_r   <= dir_s;
      q_r     <= q_s;
      r_r     <= r_s;
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
      arith_r <= arith_s;
`endif
    end
  end

  assign up_ready   = (state_r == IDLE);
  assign down_valid = (state_r == DONE);
  assign busy       = (state_r != IDLE);
  assign down_data  = data_r;

endmodule

// File: tb/tb_shift_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_step_sequencer
// Self-checking bench for shift_step_sequencer (N=8, STEP=3). Inputs change
// 1 time unit after a rising edge; outputs are sampled on falling edges.
// Expected results are queued on accept and popped when a result is handed off.
// -----------------------------------------------------------------------------
module tb_shift_step_sequencer;

  localparam int N    = 8;
  localparam int STEP = 3;

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_amt;
  logic       up_dir;
  logic       up_arith;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       busy;

  int tests_run = 0;
  int failed    = 0;

  logic [7:0] sb_q[$];

  shift_step_sequencer #(.N(N), .STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amt     (up_amt),
    .up_dir     (up_dir),
    .up_arith   (up_arith),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift using the language operators.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                       input logic dir, input logic ar);
    logic [7:0] res;
    if (!dir) begin
      res = d << a;
    end else begin
      res = d >> a;
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
      if (ar) res = 8'($signed(d) >>> a);
`endif
    end
    return res;
  endfunction

  // Scoreboard: every handed-off result must match the oldest queued one.
  always @(negedge clk) begin
    if (rst_n && down_valid && down_ready) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected: got result %02h, required none", down_data);
      end else begin
        logic [7:0] exp;
        exp = sb_q.pop_front();
        if (down_data !== exp) begin
          failed++;
          $display("FAIL sb_data: got %02h, required %02h", down_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with down_ready=1 and check latency, busy length and data.
  task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] a,
                        input logic dir, input logic ar, input int exp_lat,
                        input logic [7:0] exp_data);
    int   lat;
    int   busy_cnt;
    logic seen;
    tick();
    up_valid = 1'b1; up_data = d; up_amt = a; up_dir = dir; up_arith = ar;
    down_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (up_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_up_ready: got %b, required 1", name, up_ready);
    end
    sb_q.push_back(model(d, a, dir, ar));
    tick();
    up_valid = 1'b0;
    up_data  = 8'($urandom);
    up_amt   = 3'($urandom_range(0, 7));
    up_dir   = 1'($urandom);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (down_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || lat != exp_lat) begin
      failed++;
      $display("FAIL %s_latency: got %0d (seen=%b), required %0d", name, lat, seen, exp_lat);
    end
    tests_run++;
    if (down_data !== exp_data) begin
      failed++;
      $display("FAIL %s_data: got %02h, required %02h", name, down_data, exp_data);
    end
    tests_run++;
    if (busy_cnt != exp_lat) begin
      failed++;
      $display("FAIL %s_busy_len: got %0d, required %0d", name, busy_cnt, exp_lat);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || down_valid !== 1'b0 || up_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_handoff: busy=%b down_valid=%b up_ready=%b, required 0 0 1",
               name, busy, down_valid, up_ready);
    end
  endtask

  task automatic test_reset();
    up_valid = 1'b0; up_data = 8'h00; up_amt = 3'd0; up_dir = 1'b0;
    up_arith = 1'b0; down_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (down_valid !== 1'b0 || down_data !== 8'h00 || busy !== 1'b0 || up_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_state: dv=%b dd=%02h busy=%b ur=%b, required 0 00 0 1",
               down_valid, down_data, busy, up_ready);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_shifts();
    run_op("left_amt5",  8'hB6, 3'd5, 1'b0, 1'b0, 4, 8'hC0);
    run_op("right_amt7", 8'hB6, 3'd7, 1'b1, 1'b0, 4, 8'h01);
    run_op("left_amt0",  8'h5A, 3'd0, 1'b0, 1'b0, 1, 8'h5A);
    run_op("right_amt0", 8'h5A, 3'd0, 1'b1, 1'b0, 1, 8'h5A);
    run_op("right_amt6", 8'hF3, 3'd6, 1'b1, 1'b0, 3, 8'h03);
    run_op("left_amt1",  8'hC3, 3'd1, 1'b0, 1'b0, 2, 8'h86);
  endtask

  task automatic test_backpressure();
    int   lat;
    logic seen;
    tick();
    up_valid = 1'b1; up_data = 8'h0F; up_amt = 3'd3; up_dir = 1'b0; up_arith = 1'b0;
    down_ready = 1'b0;
    sb_q.push_back(model(8'h0F, 3'd3, 1'b0, 1'b0));
    tick();
    // Keep presenting a different request; it must be ignored.
    up_data = 8'hFF; up_amt = 3'd1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (down_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || lat != 2) begin
      failed++;
      $display("FAIL bp_latency: got %0d (seen=%b), required 2", lat, seen);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      tests_run++;
      if (down_valid !== 1'b1 || down_data !== 8'h78 || up_ready !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold%0d: dv=%b dd=%02h ur=%b, required 1 78 0",
                 i, down_valid, down_data, up_ready);
      end
    end
    tick();
    up_valid = 1'b0; down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL bp_release: ur=%b dv=%b busy=%b, required 1 0 0",
               up_ready, down_valid, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    tick();
    up_valid = 1'b1; up_data = 8'hFF; up_amt = 3'd7; up_dir = 1'b1; up_arith = 1'b0;
    down_ready = 1'b1;
    tick();
    up_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    tests_run++;
    if (down_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midrst_state: dv=%b busy=%b, required 0 0", down_valid, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
      failed++;
      $display("FAIL midrst_release: ur=%b dv=%b, required 1 0", up_ready, down_valid);
    end
    run_op("after_rst", 8'h01, 3'd1, 1'b0, 1'b0, 2, 8'h02);
  endtask

  task automatic test_arith();
`ifdef SHIFT_STEP_SEQUENCER_ARITH_EN
    run_op("arith_right", 8'h80, 3'd3, 1'b1, 1'b1, 2, 8'hF0);
    run_op("arith_pos",   8'h70, 3'd5, 1'b1, 1'b1, 4, 8'h03);
`else
    run_op("arith_right", 8'h80, 3'd3, 1'b1, 1'b1, 2, 8'h10);
    run_op("arith_pos",   8'h70, 3'd5, 1'b1, 1'b1, 4, 8'h03);
`endif
    run_op("arith_left",  8'h81, 3'd4, 1'b0, 1'b1, 3, 8'h10);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic [2:0] a;
      logic       dr;
      d  = 8'($urandom);
      a  = 3'($urandom_range(0, 7));
      dr = 1'($urandom);
      run_op("rand", d, a, dr, 1'b0, 1 + int'(a) / STEP + int'(a) % STEP,
             model(d, a, dr, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_backpressure();
    test_reset_mid_shift();
    test_arith();
    test_back_to_back();
    tick();
    tick();
    tests_run++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
